deser_1_4: RTL and testbench
============================

# deser_1_4

- Serial-to-parallel receiver: collects a 1-bit serial stream into 4-bit words.
- Each accepted bit is steered into one position of a 4-bit assembly register, selected by a 2-bit position counter.
- This is the inverse of the 4:1 select path that produces the serial stream at the transmitting end.
- Sits at the receive end of the team's 4-bit serial link and hands complete words downstream over a valid/ready interface.

## Interface

Parameters:
- `LSB_FIRST`, default 1. When 1, the first bit of a frame lands in bit 0. When 0, the first bit lands in bit 3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_bit` carries a valid serial bit.
- `in_bit`  in  1  serial data bit.
- `in_ready`  out  1  the block accepts `in_bit` this cycle.
- `sync`  in  1  frame realign; discards the partial frame.
- `out_valid`  out  1  `out_word` holds a complete word.
- `out_word`  out  4  assembled word.
- `out_ready`  in  1  downstream consumes `out_word`.
- `parity_err`  out  1  only present when `DESER_PARITY_EN` is defined; see Configuration.

## Operation

- A bit is accepted when `in_valid && in_ready`.
- Position counter `idx` counts 0..LAST. LAST = 3, or 4 with parity enabled.
- Accepting a data bit at `idx` < 4 writes it into the assembly register:
  - `asm[idx]` when `LSB_FIRST`=1;
  - `asm[3-idx]` when `LSB_FIRST`=0.
  - Then `idx` increments.
- Accepting a bit at `idx`==LAST completes the frame:
  - the completed word, including the bit accepted this cycle, is loaded into `out_word`;
  - `out_valid` is set to 1;
  - `idx` wraps to 0.
- Output holding register:
  - `out_valid` clears on `out_valid && out_ready` unless a new frame completes in the same cycle;
  - if one does, `out_valid` stays 1 and `out_word` takes the new word.
- `in_ready` = (`idx` != LAST) || !`out_valid` || `out_ready`.
  - Mid-frame bits are never stalled.
  - Only the completing bit can be back-pressured.
- `sync`:
  - sets `idx` to 0 and clears `asm`;
  - `out_valid` and `out_word` are unaffected;
  - if `in_valid` is high in the same cycle, that bit is taken as bit 0 of the new frame.
- Idle cycles (`in_valid`=0) between bits hold all state.
- Reset values:
  - `idx`=0, `asm`=0;
  - `out_valid`=0, `out_word`=4'h0;
  - `parity_err`=0;
  - `in_ready`=1 after reset.
- `rst` mid-frame discards the partial frame and any held word.

## Timing

- `out_valid` rises on the clock edge that accepts the last bit of a frame. It is visible the cycle after the last bit is presented.
- Sustained throughput is one bit per cycle, i.e. one word every 4 cycles (5 with parity), with `out_ready` held high.
- `out_word` is stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is combinational from `out_ready`. `out_valid` and `out_word` are registered.

## Configuration

- Macro: `DESER_PARITY_EN`.
- Defined:
  - frame is 5 bits: 4 data bits, then one even-parity bit;
  - `idx` is 3 bits;
  - `parity_err` port exists, registered alongside `out_word`, and is valid while `out_valid`=1;
  - `parity_err`=1 when XOR(data, parity bit) = 1.
- Undefined:
  - frame is 4 bits;
  - `idx` is 2 bits;
  - no `parity_err` port and no parity logic.

## Structure

- Shared include `deser_defs.vh` holds:
  - `DESER_WORD_W` = 4;
  - `DESER_FRAME_LAST` (3, or 4 when `DESER_PARITY_EN` is defined).
- One sub-module: `demux_1_4`, combinational.
  - Inputs: `d`, `s[1:0]`, `en`. Output: one-hot `y[3:0]`.
  - Generates per-bit write enables for `asm`.

## Test plan

- Reset: assert `rst` 2 cycles with `in_valid`=1 → `out_valid`=0, `out_word`=0, `in_ready`=1, no bits captured.
- `LSB_FIRST`=1, `out_ready`=1, bits 1,0,1,1 on consecutive cycles → `out_word`=4'hD, `out_valid` high for exactly 1 cycle after the 4th bit.
- `LSB_FIRST`=0, bits 1,1,0,1 with 2 idle cycles between each → `out_word`=4'hD.
- Backpressure:
  - `out_ready`=0, stream frames 0xA then 0x5;
  - `in_ready` drops on the 4th bit of 0x5 and 0xA is held;
  - pulse `out_ready` → 0xA consumed, 0x5 accepted in the same cycle, then `out_word`=0x5 with `out_valid` still high.
- `sync` after 2 bits, then bits 0,0,1,0 → single word 4'h4, no word from the partial frame.
- `DESER_PARITY_EN`:
  - data 0xD + parity 1 → `parity_err`=0;
  - data 0xD + parity 0 → `parity_err`=1.

Source files
------------

// File: rtl/deser_1_4_pkg.sv
// deser_1_4_pkg - shared widths, frame geometry and helpers for the 1:4 deserialiser.
// Optional feature macro: DESER_PARITY_EN (each frame carries a trailing even-parity bit).
// The DESER_* defines below are the link-wide definitions shared by every file of this slice.

`ifndef DESER_DEFS_VH
`define DESER_DEFS_VH
`define DESER_WORD_W 4
`ifdef DESER_PARITY_EN
`define DESER_FRAME_LAST 4
`else
`define DESER_FRAME_LAST 3
`endif
`endif

package deser_1_4_pkg;

  localparam int WORD_W = `DESER_WORD_W;

`ifdef DESER_PARITY_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  // Position of the final bit of a frame; accepting it completes the word.
  localparam logic [IDX_W-1:0] FRAME_LAST = IDX_W'(`DESER_FRAME_LAST);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  // Contents of the output holding register handed downstream.
  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] word;
`ifdef DESER_PARITY_EN
    logic              perr;
`endif
  } outHold_t;

  // Maps a serial data position onto its slot in the assembly register.
  function automatic logic [1:0] slotOf(input logic [1:0] idx, input logic lsbFirst);
    return lsbFirst ? idx : (2'd3 - idx);
  endfunction

endpackage

// File: rtl/demux_1_4.sv
// demux_1_4 - combinational 1:4 demultiplexer producing one-hot per-bit write enables
// for the deserialiser's assembly register. Mirrors the 4:1 select at the transmitter.

module demux_1_4
  import deser_1_4_pkg::*;
(
  input  logic              d,
  input  logic [1:0]        s,
  input  logic              en,
  output logic [WORD_W-1:0] y
);

  // Steer d onto the selected output only; all other outputs stay low.
  always_comb begin
    y    = '0;
    y[s] = d & en;
  end

endmodule

// File: rtl/deser_1_4.sv
// deser_1_4 - serial-to-parallel receiver: gathers a 1-bit stream into 4-bit words and
// offers each completed word over a valid/ready handshake.
// Optional feature macro: DESER_PARITY_EN (5-bit frames with even parity, adds parity_err).

module deser_1_4
  import deser_1_4_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  input  logic              sync,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_word,
  input  logic              out_ready
`ifdef DESER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  outHold_t          out_q, out_d;

  logic [IDX_W-1:0]  curIdx;
  logic [WORD_W-1:0] curAsm;
  logic [WORD_W-1:0] wrEn;
  logic [1:0]        slot;
  logic              accept;
  logic              dataBit;
  logic              complete;

  // Only the frame-completing bit can be stalled, and only while a word is still held.
  assign in_ready = (idx_q != FRAME_LAST) || !out_q.valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A sync realigns to the start of a fresh frame before this cycle's bit is placed.
  always_comb begin
    curIdx = sync ? '0 : idx_q;
    curAsm = sync ? '0 : asm_q;
  end

`ifdef DESER_PARITY_EN
  assign dataBit = accept && (curIdx != FRAME_LAST);
  assign slot    = slotOf(curIdx[1:0], LSB_FIRST != 0);
`else
  assign dataBit = accept;
  assign slot    = slotOf(curIdx, LSB_FIRST != 0);
`endif

  assign complete = accept && (curIdx == FRAME_LAST);

  demux_1_4 u_demux (
    .d  (1'b1),
    .s  (slot),
    .en (dataBit),
    .y  (wrEn)
  );

  // Write the accepted data bit into its enabled slot of the assembly register.
  always_comb begin
    asm_d = curAsm;
    for (int k = 0; k < WORD_W; k++) begin
      if (wrEn[k]) begin
        asm_d[k] = in_bit;
      end
    end
  end

  // Advance the position counter on each accepted bit, wrapping after the last one.
  always_comb begin
    idx_d = curIdx;
    if (accept) begin
      idx_d = complete ? '0 : (curIdx + IDX_ONE);
    end
  end

  // Holding register: drained by the consumer, reloaded when a frame completes.
  always_comb begin
    out_d = out_q;
    if (out_q.valid && out_ready) begin
      out_d.valid = 1'b0;
    end
    if (complete) begin
      out_d.valid = 1'b1;
      out_d.word  = asm_d;
`ifdef DESER_PARITY_EN
      out_d.perr  = ^{curAsm, in_bit};
`endif
    end
  end

  // State registers with synchronous reset discarding any partial frame and held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      asm_q <= '0;
      out_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
      out_q <= out_d;
    end
  end

  assign out_valid = out_q.valid;
  assign out_word  = out_q.word;
`ifdef DESER_PARITY_EN
  assign parity_err = out_q.perr;
`endif

endmodule

// File: tb/tb_deser_1_4.sv
// tb_deser_1_4 - bench for deser_1_4; drives an LSB-first and an MSB-first instance
// from the same serial stream and compares both against a bit-queue model.
// Optional feature macro: DESER_PARITY_EN (must match the RTL build).

module tb_deser_1_4;

`ifdef DESER_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inBit;
  logic       syncIn;
  logic       outReady;

  logic       inReadyL, outValidL;
  logic [3:0] outWordL;
  logic       inReadyM, outValidM;
  logic [3:0] outWordM;
`ifdef DESER_PARITY_EN
  logic       parityErrL, parityErrM;
`endif

  logic       mBits[$];
  logic       expValid;
  logic [3:0] expWordL;
  logic [3:0] expWordM;
`ifdef DESER_PARITY_EN
  logic       expPerr;
`endif
  logic       mAcc;
  logic       checking;
  int         nChecks;
  int         nFails;

  always #5 clk = ~clk;

  deser_1_4 #(.LSB_FIRST(1)) dutL (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_bit    (inBit),
    .in_ready  (inReadyL),
    .sync      (syncIn),
    .out_valid (outValidL),
    .out_word  (outWordL),
    .out_ready (outReady)
`ifdef DESER_PARITY_EN
    ,
    .parity_err(parityErrL)
`endif
  );

  deser_1_4 #(.LSB_FIRST(0)) dutM (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_bit    (inBit),
    .in_ready  (inReadyM),
    .sync      (syncIn),
    .out_valid (outValidM),
    .out_word  (outWordM),
    .out_ready (outReady)
`ifdef DESER_PARITY_EN
    ,
    .parity_err(parityErrM)
`endif
  );

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // A bit is refused only when it would complete a frame while a word is still unconsumed.
  function automatic logic modelReady();
    return !((mBits.size() == FRAME_LEN - 1) && expValid) || outReady;
  endfunction

  // Build the word from the collected frame bits in arrival order.
  function automatic logic [3:0] packWord(input logic lsb);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (lsb) w[i] = mBits[i];
      else     w[3 - i] = mBits[i];
    end
    return w;
  endfunction

  // Bit i of a frame: data bits in f[0..3] order, then even parity optionally inverted.
  function automatic logic frameBit(input logic [3:0] f, input int i, input logic flip);
    if (i < 4) return f[i];
    return (^f) ^ flip;
  endfunction

  // Behavioural model updated on each rising edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mBits.delete();
      expValid = 1'b0;
      expWordL = 4'h0;
      expWordM = 4'h0;
`ifdef DESER_PARITY_EN
      expPerr  = 1'b0;
`endif
    end else begin
      mAcc = inValid && modelReady();
      if (syncIn) mBits.delete();
      if (expValid && outReady) expValid = 1'b0;
      if (mAcc) begin
        mBits.push_back(inBit);
        if (mBits.size() == FRAME_LEN) begin
          expWordL = packWord(1'b1);
          expWordM = packWord(1'b0);
`ifdef DESER_PARITY_EN
          expPerr = 1'b0;
          for (int i = 0; i < FRAME_LEN; i++) expPerr = expPerr ^ mBits[i];
`endif
          expValid = 1'b1;
          mBits.delete();
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      checkOutput("in_ready_lsb",  {3'b000, inReadyL},  {3'b000, modelReady()});
      checkOutput("in_ready_msb",  {3'b000, inReadyM},  {3'b000, modelReady()});
      checkOutput("out_valid_lsb", {3'b000, outValidL}, {3'b000, expValid});
      checkOutput("out_valid_msb", {3'b000, outValidM}, {3'b000, expValid});
      checkOutput("out_word_lsb",  outWordL, expWordL);
      checkOutput("out_word_msb",  outWordM, expWordM);
`ifdef DESER_PARITY_EN
      if (expValid) begin
        checkOutput("parity_err_lsb", {3'b000, parityErrL}, {3'b000, expPerr});
        checkOutput("parity_err_msb", {3'b000, parityErrM}, {3'b000, expPerr});
      end
`endif
    end
  end

  task automatic applyStimulus(input logic v, input logic b, input logic s);
    inValid = v;
    inBit   = b;
    syncIn  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [3:0] f, input int gap, input logic flip, input logic syncFirst);
    for (int i = 0; i < FRAME_LEN; i++) begin
      applyStimulus(1'b1, frameBit(f, i, flip), (i == 0) && syncFirst);
      if (i != FRAME_LEN - 1) begin
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
    inValid = 1'b0;
    syncIn  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks  = 0;
    nFails   = 0;
    checking = 1'b0;
    rst      = 1'b1;
    inValid  = 1'b1;
    inBit    = 1'b1;
    syncIn   = 1'b0;
    outReady = 1'b1;

    // Reset held for two cycles with valid bits offered.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rst_valid",    {3'b000, outValidL}, 4'h0);
    checkOutput("rst_word_lsb", outWordL, 4'h0);
    checkOutput("rst_word_msb", outWordM, 4'h0);
    checkOutput("rst_ready",    {3'b000, inReadyL}, 4'h1);
    rst = 1'b0;

    // Back-to-back bits 1,0,1,1.
    sendFrame(4'b1101, 0, 1'b0, 1'b0);
    checkOutput("b2b_valid",    {3'b000, outValidL}, 4'h1);
    checkOutput("b2b_word_lsb", outWordL, 4'hD);
    checkOutput("b2b_word_msb", outWordM, 4'hB);
    checkOutput("model_b2b",    expWordL, 4'hD);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("b2b_one_cycle", {3'b000, outValidL}, 4'h0);

    // Bits 1,1,0,1 with two idle cycles between each.
    sendFrame(4'b1011, 2, 1'b0, 1'b0);
    checkOutput("gap_word_msb", outWordM, 4'hD);
    checkOutput("gap_word_lsb", outWordL, 4'hB);
    checkOutput("model_gap",    expWordM, 4'hD);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Backpressure: 0xA held while the completing bit of 0x5 waits.
    outReady = 1'b0;
    sendFrame(4'hA, 0, 1'b0, 1'b0);
    checkOutput("bp_first_valid", {3'b000, outValidL}, 4'h1);
    checkOutput("bp_first_word",  outWordL, 4'hA);
    for (int i = 0; i < FRAME_LEN - 1; i++) applyStimulus(1'b1, frameBit(4'h5, i, 1'b0), 1'b0);
    inValid = 1'b1;
    inBit   = frameBit(4'h5, FRAME_LEN - 1, 1'b0);
    #1;
    checkOutput("bp_ready_low", {3'b000, inReadyL}, 4'h0);
    applyStimulus(1'b1, frameBit(4'h5, FRAME_LEN - 1, 1'b0), 1'b0);
    applyStimulus(1'b1, frameBit(4'h5, FRAME_LEN - 1, 1'b0), 1'b0);
    checkOutput("bp_hold_word",  outWordL, 4'hA);
    checkOutput("bp_hold_valid", {3'b000, outValidL}, 4'h1);
    outReady = 1'b1;
    applyStimulus(1'b1, frameBit(4'h5, FRAME_LEN - 1, 1'b0), 1'b0);
    outReady = 1'b0;
    inValid  = 1'b0;
    checkOutput("bp_new_valid",    {3'b000, outValidL}, 4'h1);
    checkOutput("bp_new_word",     outWordL, 4'h5);
    checkOutput("bp_new_word_msb", outWordM, 4'hA);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_still_word", outWordL, 4'h5);
    outReady = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bp_drained", {3'b000, outValidL}, 4'h0);

    // Sync after two bits; the new frame starts in the sync cycle.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sync_partial_none", {3'b000, outValidL}, 4'h0);
    sendFrame(4'b0100, 0, 1'b0, 1'b1);
    checkOutput("sync_valid",    {3'b000, outValidL}, 4'h1);
    checkOutput("sync_word_lsb", outWordL, 4'h4);
    checkOutput("sync_word_msb", outWordM, 4'h2);
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef DESER_PARITY_EN
    // Even parity good and bad on data 0xD.
    sendFrame(4'b1101, 0, 1'b0, 1'b0);
    checkOutput("par_ok",      {3'b000, parityErrL}, 4'h0);
    checkOutput("par_ok_word", outWordL, 4'hD);
    sendFrame(4'b1101, 0, 1'b1, 1'b0);
    checkOutput("par_bad",      {3'b000, parityErrL}, 4'h1);
    checkOutput("par_bad_msb",  {3'b000, parityErrM}, 4'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-frame with a word still held.
    outReady = 1'b0;
    sendFrame(4'h3, 0, 1'b0, 1'b0);
    checkOutput("mid_rst_held", {3'b000, outValidL}, 4'h1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    inValid = 1'b0;
    checkOutput("mid_rst_valid", {3'b000, outValidL}, 4'h0);
    checkOutput("mid_rst_word",  outWordL, 4'h0);
    checkOutput("mid_rst_ready", {3'b000, inReadyL}, 4'h1);
    outReady = 1'b1;
    sendFrame(4'h6, 0, 1'b0, 1'b0);
    checkOutput("post_rst_word_lsb", outWordL, 4'h6);
    checkOutput("post_rst_word_msb", outWordM, 4'h6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
